// File: rtl/csr_regfile_pkg.sv
// Shared machine-mode CSR definitions: address map and write masks used by the
// CSR register file and the CLINT sequencing logic.
package csr_regfile_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // MIE (bit 3) and MPIE (bit 7) are the only software-visible mstatus state.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    // Machine-only hart: MPP is hardwired to 2'b11.
    localparam logic [31:0] MSTATUS_MPP_M = 32'h0000_1800;

endpackage

// File: rtl/csr_regfile_counter64.sv
// 64-bit counter with independently writable halves; any write freezes the
// increment for the whole counter that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [63:0] wd,
    output logic [63:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wd[31:0];
            if (wr_hi) value[63:32] <= wd[63:32];
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: CLINT and EX write ports, combinational ID
// read port, and the mcycle/minstret counters.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] MHARTID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] id_csr_ra,
    output logic [31:0] id_csr_rd,
    output logic        id_csr_illegal,
    input  logic        ex_csr_we,
    input  logic [11:0] ex_csr_wa,
    input  logic [31:0] ex_csr_wd,
    input  logic        clint_csr_we,
    input  logic [11:0] clint_csr_wa,
    input  logic [31:0] clint_csr_wd,
    input  logic        inst_retire,
    output logic [31:0] csr_mtvec,
    output logic [31:0] csr_mepc,
    output logic [31:0] csr_mstatus,
    output logic        interrupt_enable
);

    // {hit, data} for one address; the CLINT port takes priority on a collision.
    function automatic logic [32:0] wsel(
        input logic [11:0] a,
        input logic        cwe,
        input logic [11:0] cwa,
        input logic [31:0] cwd,
        input logic        ewe,
        input logic [11:0] ewa,
        input logic [31:0] ewd
    );
        if (cwe && cwa == a) return {1'b1, cwd};
        if (ewe && ewa == a) return {1'b1, ewd};
        return {1'b0, ewd};
    endfunction

    logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause;
    logic [32:0] w_mcycle, w_mcycleh, w_minstret, w_minstreth;

    assign w_mstatus   = wsel(CSR_MSTATUS,   clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mie       = wsel(CSR_MIE,       clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mtvec     = wsel(CSR_MTVEC,     clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mscratch  = wsel(CSR_MSCRATCH,  clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mepc      = wsel(CSR_MEPC,      clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mcause    = wsel(CSR_MCAUSE,    clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mcycle    = wsel(CSR_MCYCLE,    clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_mcycleh   = wsel(CSR_MCYCLEH,   clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_minstret  = wsel(CSR_MINSTRET,  clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);
    assign w_minstreth = wsel(CSR_MINSTRETH, clint_csr_we, clint_csr_wa, clint_csr_wd, ex_csr_we, ex_csr_wa, ex_csr_wd);

    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle, minstret;

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus  <= MSTATUS_MPP_M;
            mie      <= 32'd0;
            mtvec    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch <= 32'd0;
            mepc     <= 32'd0;
            mcause   <= 32'd0;
        end else begin
            if (w_mstatus[32])  mstatus  <= (w_mstatus[31:0] & MSTATUS_WMASK) | MSTATUS_MPP_M;
            if (w_mie[32])      mie      <= w_mie[31:0] & MIE_WMASK;
            if (w_mtvec[32])    mtvec    <= {w_mtvec[31:2], 2'b00};
            if (w_mscratch[32]) mscratch <= w_mscratch[31:0];
            if (w_mepc[32])     mepc     <= {w_mepc[31:2], 2'b00};
            if (w_mcause[32])   mcause   <= w_mcause[31:0];
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (w_mcycle[32]),
        .wr_hi (w_mcycleh[32]),
        .wd    ({w_mcycleh[31:0], w_mcycle[31:0]}),
        .value (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (inst_retire),
        .wr_lo (w_minstret[32]),
        .wr_hi (w_minstreth[32]),
        .wd    ({w_minstreth[31:0], w_minstret[31:0]}),
        .value (minstret)
    );

    // Read port sees only committed state; a same-cycle write shows up next cycle.
    always_comb begin
        id_csr_rd      = 32'd0;
        id_csr_illegal = 1'b0;
        case (id_csr_ra)
            CSR_MSTATUS:                 id_csr_rd = mstatus;
            CSR_MIE:                     id_csr_rd = mie;
            CSR_MTVEC:                   id_csr_rd = mtvec;
            CSR_MSCRATCH:                id_csr_rd = mscratch;
            CSR_MEPC:                    id_csr_rd = mepc;
            CSR_MCAUSE:                  id_csr_rd = mcause;
            CSR_MCYCLE,   CSR_CYCLE:     id_csr_rd = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    id_csr_rd = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   id_csr_rd = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: id_csr_rd = minstret[63:32];
            CSR_MHARTID:                 id_csr_rd = MHARTID;
            default:                     id_csr_illegal = 1'b1;
        endcase
    end

    assign csr_mtvec        = mtvec;
    assign csr_mepc         = mepc;
    assign csr_mstatus      = mstatus;
    assign interrupt_enable = mstatus[3];

endmodule

// File: tb/tb_csr_regfile.sv
// Bench for csr_regfile: expected read results are queued as writes are driven
// and drained through the combinational read port once the writes have landed.
module tb_csr_regfile;

    localparam logic [31:0] HART  = 32'h0000_0042;
    localparam logic [31:0] TVEC0 = 32'h0000_1003;
    localparam logic [31:0] TVEC0_EXP = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] id_csr_ra;
    logic [31:0] id_csr_rd;
    logic        id_csr_illegal;
    logic        ex_csr_we;
    logic [11:0] ex_csr_wa;
    logic [31:0] ex_csr_wd;
    logic        clint_csr_we;
    logic [11:0] clint_csr_wa;
    logic [31:0] clint_csr_wd;
    logic        inst_retire;
    logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
    logic        interrupt_enable;

    csr_regfile #(.MHARTID(HART), .MTVEC_RESET(TVEC0)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_csr_ra        (id_csr_ra),
        .id_csr_rd        (id_csr_rd),
        .id_csr_illegal   (id_csr_illegal),
        .ex_csr_we        (ex_csr_we),
        .ex_csr_wa        (ex_csr_wa),
        .ex_csr_wd        (ex_csr_wd),
        .clint_csr_we     (clint_csr_we),
        .clint_csr_wa     (clint_csr_wa),
        .clint_csr_wd     (clint_csr_wd),
        .inst_retire      (inst_retire),
        .csr_mtvec        (csr_mtvec),
        .csr_mepc         (csr_mepc),
        .csr_mstatus      (csr_mstatus),
        .interrupt_enable (interrupt_enable)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        ill;
    } rd_exp_t;

    rd_exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_rd(input logic [11:0] a, input logic [31:0] d, input logic ill);
        rd_exp_t e;
        e.addr = a;
        e.data = d;
        e.ill  = ill;
        sb.push_back(e);
    endtask

    // Drains within one clock phase: each read takes 1ns of a 100ns period.
    task automatic drain();
        rd_exp_t e;
        string   tag;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            id_csr_ra = e.addr;
            #1;
            tag = $sformatf("rd_%h", e.addr);
            check_val(tag, id_csr_rd, e.data);
            tag = $sformatf("ill_%h", e.addr);
            check_val(tag, {31'd0, id_csr_illegal}, {31'd0, e.ill});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_csr_we    = 1'b0;
        clint_csr_we = 1'b0;
        inst_retire  = 1'b0;
    endtask

    task automatic ex_wr(input logic [11:0] a, input logic [31:0] d);
        ex_csr_we = 1'b1;
        ex_csr_wa = a;
        ex_csr_wd = d;
    endtask

    task automatic clint_wr(input logic [11:0] a, input logic [31:0] d);
        clint_csr_we = 1'b1;
        clint_csr_wa = a;
        clint_csr_wd = d;
    endtask

    initial begin
        rst = 1'b1;
        id_csr_ra = 12'h000;
        ex_csr_wa = 12'h000;
        ex_csr_wd = 32'd0;
        clint_csr_wa = 12'h000;
        clint_csr_wd = 32'd0;
        idle();
        tick();

        // reset state
        rst = 1'b0;
        check_val("rst_mstatus", csr_mstatus, 32'h0000_1800);
        check_val("rst_mie_out", {31'd0, interrupt_enable}, 32'd0);
        check_val("rst_mepc", csr_mepc, 32'd0);
        check_val("rst_mtvec", csr_mtvec, TVEC0_EXP);
        push_rd(12'h300, 32'h0000_1800, 1'b0);
        push_rd(12'h305, TVEC0_EXP, 1'b0);
        push_rd(12'h7C0, 32'd0, 1'b1);
        push_rd(12'hB00, 32'd0, 1'b0);
        push_rd(12'hB02, 32'd0, 1'b0);
        push_rd(12'hF14, HART, 1'b0);
        push_rd(12'h341, 32'd0, 1'b0);
        ex_wr(12'h300, 32'hFFFF_FFFF);
        drain();
        tick();

        // mstatus mask, then mepc alignment
        check_val("mstatus_wr", csr_mstatus, 32'h0000_1888);
        check_val("mie_bit", {31'd0, interrupt_enable}, 32'd1);
        push_rd(12'h300, 32'h0000_1888, 1'b0);
        ex_wr(12'h341, 32'h8000_0103);
        drain();
        tick();
        check_val("mepc_wr", csr_mepc, 32'h8000_0100);
        push_rd(12'h341, 32'h8000_0100, 1'b0);

        // same-address collision: CLINT wins
        clint_wr(12'h342, 32'h8000_000B);
        ex_wr(12'h342, 32'd5);
        drain();
        tick();
        push_rd(12'h342, 32'h8000_000B, 1'b0);

        // different addresses: both land
        clint_wr(12'h342, 32'h8000_0003);
        ex_wr(12'h340, 32'h0000_A5A5);
        drain();
        tick();
        idle();
        push_rd(12'h342, 32'h8000_0003, 1'b0);
        push_rd(12'h340, 32'h0000_A5A5, 1'b0);
        ex_wr(12'h304, 32'hFFFF_FFFF);
        drain();
        tick();
        push_rd(12'h304, 32'h0000_0888, 1'b0);
        ex_wr(12'h305, 32'h8000_0107);
        drain();
        tick();
        check_val("mtvec_wr", csr_mtvec, 32'h8000_0104);

        // mcycle low write, then high write, then carry on wrap
        ex_wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        ex_wr(12'hB80, 32'd0);
        push_rd(12'hB00, 32'hFFFF_FFFF, 1'b0);
        drain();
        tick();
        idle();
        push_rd(12'hB00, 32'hFFFF_FFFF, 1'b0);
        push_rd(12'hB80, 32'd0, 1'b0);
        push_rd(12'hC00, 32'hFFFF_FFFF, 1'b0);
        drain();
        tick();
        push_rd(12'hB00, 32'd0, 1'b0);
        push_rd(12'hB80, 32'd1, 1'b0);
        push_rd(12'hC80, 32'd1, 1'b0);
        drain();

        // minstret: 3 + 1 retirements
        inst_retire = 1'b1;
        repeat (3) tick();
        inst_retire = 1'b0;
        repeat (2) tick();
        inst_retire = 1'b1;
        tick();
        inst_retire = 1'b0;
        push_rd(12'hB02, 32'd4, 1'b0);
        push_rd(12'hC02, 32'd4, 1'b0);
        ex_wr(12'hC02, 32'd7);
        drain();
        tick();
        ex_wr(12'h7C0, 32'h1234_5678);
        tick();
        idle();
        push_rd(12'hC02, 32'd4, 1'b0);
        push_rd(12'hB02, 32'd4, 1'b0);
        push_rd(12'hB82, 32'd0, 1'b0);
        push_rd(12'h7C0, 32'd0, 1'b1);
        drain();

        // reset mid-stream dominates a concurrent write
        rst = 1'b1;
        ex_wr(12'h305, 32'h1234_5678);
        tick();
        rst = 1'b0;
        idle();
        check_val("rst2_mtvec", csr_mtvec, TVEC0_EXP);
        check_val("rst2_mstatus", csr_mstatus, 32'h0000_1800);
        check_val("rst2_ie", {31'd0, interrupt_enable}, 32'd0);
        push_rd(12'hB00, 32'd0, 1'b0);
        push_rd(12'hB80, 32'd0, 1'b0);
        push_rd(12'hB02, 32'd0, 1'b0);
        push_rd(12'h342, 32'd0, 1'b0);
        drain();
        tick();
        push_rd(12'hB00, 32'd1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
